// File: rtl/matrix_unloader.sv
// rtl/matrix_unloader.sv - streams a result matrix off-chip as a dimension header followed by MS-first element nibbles
module matrix_unloader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              start,
  input  logic [3:0]        rows,
  input  logic [3:0]        cols,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [3:0]        data,
  output logic              ctrl_logic,
  output logic              valid,
  input  logic              ready,
  output logic              busy,
  output logic              done
);

  localparam int NIBS  = DATA_W / 4;
  localparam int NIB_W = $clog2(NIBS + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR_R, S_HDR_C, S_FETCH, S_WAIT, S_SEND, S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [3:0]          cols_q, cols_nx;
  logic [7:0]          total, total_nx;
  logic [7:0]          elem_idx, elem_nx;
  logic [7:0]          elem_inc;
  logic [NIB_W-1:0]    nib_idx, nib_nx;
  logic [DATA_W-1:0]   sh, sh_nx, sh_shift;
  logic [3:0]          data_nx;
  logic                ctrl_nx, valid_nx, rd_en_nx, busy_nx, done_nx;
  logic [ADDR_W-1:0]   rd_addr_nx;

  assign elem_inc = elem_idx + 8'd1;
  assign sh_shift = sh << 4;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      cols_q     <= '0;
      total      <= '0;
      elem_idx   <= '0;
      nib_idx    <= '0;
      sh         <= '0;
      data       <= '0;
      ctrl_logic <= 1'b0;
      valid      <= 1'b0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      cols_q     <= cols_nx;
      total      <= total_nx;
      elem_idx   <= elem_nx;
      nib_idx    <= nib_nx;
      sh         <= sh_nx;
      data       <= data_nx;
      ctrl_logic <= ctrl_nx;
      valid      <= valid_nx;
      rd_en      <= rd_en_nx;
      rd_addr    <= rd_addr_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // Outputs are registered: each branch computes what the bus shows in the next state.
  always_comb begin
    state_nx   = state;
    cols_nx    = cols_q;
    total_nx   = total;
    elem_nx    = elem_idx;
    nib_nx     = nib_idx;
    sh_nx      = sh;
    data_nx    = data;
    ctrl_nx    = ctrl_logic;
    valid_nx   = valid;
    rd_en_nx   = 1'b0;
    rd_addr_nx = rd_addr;
    busy_nx    = busy;
    done_nx    = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          cols_nx    = cols;
          total_nx   = {4'd0, rows} * {4'd0, cols};
          elem_nx    = '0;
          rd_addr_nx = '0;
          busy_nx    = 1'b1;
          valid_nx   = 1'b1;
          ctrl_nx    = 1'b1;
          data_nx    = rows;
          state_nx   = S_HDR_R;
        end
      end
      S_HDR_R: begin
        if (ready) begin
          data_nx  = cols_q;
          state_nx = S_HDR_C;
        end
      end
      S_HDR_C: begin
        if (ready) begin
          valid_nx = 1'b0;
          ctrl_nx  = 1'b0;
          if (total != 8'd0) begin
            rd_en_nx   = 1'b1;
            rd_addr_nx = ADDR_W'(elem_idx);
            state_nx   = S_FETCH;
          end else begin
            done_nx  = 1'b1;
            state_nx = S_DONE;
          end
        end
      end
      S_FETCH: begin
        state_nx = S_WAIT;
      end
      S_WAIT: begin
        sh_nx    = rd_data;
        nib_nx   = '0;
        data_nx  = rd_data[DATA_W-1 -: 4];
        ctrl_nx  = 1'b0;
        valid_nx = 1'b1;
        state_nx = S_SEND;
      end
      S_SEND: begin
        if (ready) begin
          sh_nx   = sh_shift;
          data_nx = sh_shift[DATA_W-1 -: 4];
          nib_nx  = nib_idx + 1'b1;
          if (nib_idx == NIB_W'(NIBS - 1)) begin
            elem_nx  = elem_inc;
            valid_nx = 1'b0;
            // Address advances by one per element, so row-major order needs no multiplier.
            if (elem_inc < total) begin
              rd_en_nx   = 1'b1;
              rd_addr_nx = ADDR_W'(elem_inc);
              state_nx   = S_FETCH;
            end else begin
              done_nx  = 1'b1;
              state_nx = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_matrix_unloader.sv
// tb/tb_matrix_unloader.sv - table-driven bench for matrix_unloader with a registered-read buffer model
module tb_matrix_unloader;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic [3:0]  rows, cols;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] rd_data;
  logic [3:0]  data;
  logic        ctrl_logic, valid, ready, busy, done;

  matrix_unloader #(.DATA_W(16), .ADDR_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .start(start), .rows(rows), .cols(cols),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .data(data), .ctrl_logic(ctrl_logic), .valid(valid), .ready(ready),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic [15:0] mem [0:255];
  always @(posedge CLK) if (rd_en) rd_data <= mem[rd_addr];

  bit rmode;
  always @(posedge CLK) begin
    #1;
    ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic [4:0] hs_q[$];
  logic [7:0] addr_q[$];
  int         done_cnt = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [3:0] pd = '0;
  logic       pc = 1'b0;

  always @(negedge CLK) begin
    if (!RST_N) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall && (!valid || data !== pd || ctrl_logic !== pc)) stall_err <= stall_err + 1;
      if (valid && ready) hs_q.push_back({ctrl_logic, data});
      if (rd_en) addr_q.push_back(rd_addr);
      if (done) done_cnt <= done_cnt + 1;
      prev_stall <= valid && !ready;
      pd <= data;
      pc <= ctrl_logic;
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic [3:0] r;
    logic [3:0] c;
    bit         pat;
    bit         rnd;
    bit         glitch;
    int         nibs;
    int         reads;
  } vec_t;

  vec_t vecs[7];

  task automatic fill_mem(input bit pat);
    for (int i = 0; i < 256; i++)
      mem[i] = pat ? 16'(i) : 16'(16'h1000 * i + 16'h0ABC);
  endtask

  task automatic run(input int k);
    vec_t       v;
    logic [4:0] exp_q[$];
    int         hs0, a0, d0, st0, n, mism, total;
    logic [15:0] w;
    v = vecs[k];
    fill_mem(v.pat);
    rmode = v.rnd;
    hs0 = hs_q.size(); a0 = addr_q.size(); d0 = done_cnt; st0 = stall_err;
    @(negedge CLK);
    start = 1'b1; rows = v.r; cols = v.c;
    @(negedge CLK);
    start = 1'b0;
    chk($sformatf("v%0d hdr_latency", k), {27'd0, busy, valid, ctrl_logic, data}, {27'd0, 3'b111, v.r});
    if (v.glitch) begin
      repeat (4) @(negedge CLK);
      start = 1'b1; rows = ~v.r; cols = ~v.c;
      @(negedge CLK);
      start = 1'b0;
    end
    for (int c = 0; c < 20000 && done_cnt == d0; c++) @(posedge CLK);
    repeat (3) @(negedge CLK);
    chk($sformatf("v%0d done_pulses", k), done_cnt - d0, 1);
    chk($sformatf("v%0d idle_after", k), {30'd0, busy, valid}, 0);
    chk($sformatf("v%0d stall_violations", k), stall_err - st0, 0);

    total = v.r * v.c;
    exp_q.push_back({1'b1, v.r});
    exp_q.push_back({1'b1, v.c});
    for (int e = 0; e < total; e++) begin
      w = mem[e];
      for (int j = 0; j < 4; j++) exp_q.push_back({1'b0, w[15 - 4*j -: 4]});
    end
    n = hs_q.size() - hs0;
    chk($sformatf("v%0d nibble_count", k), n, v.nibs);
    mism = 0;
    for (int i = 0; i < exp_q.size() && i < n; i++)
      if (hs_q[hs0 + i] !== exp_q[i]) mism++;
    chk($sformatf("v%0d stream_mismatches", k), mism, 0);

    chk($sformatf("v%0d read_count", k), addr_q.size() - a0, v.reads);
    mism = 0;
    for (int i = a0; i < addr_q.size(); i++)
      if (addr_q[i] !== 8'(i - a0)) mism++;
    chk($sformatf("v%0d addr_sequence", k), mism, 0);

    if (v.r == 4'd15 && v.c == 4'd15 && n >= 4) begin
      chk("last_elem_n0", hs_q[hs0 + n - 4], 5'h00);
      chk("last_elem_n1", hs_q[hs0 + n - 3], 5'h00);
      chk("last_elem_n2", hs_q[hs0 + n - 2], 5'h0E);
      chk("last_elem_n3", hs_q[hs0 + n - 1], 5'h00);
      chk("last_addr", addr_q[addr_q.size() - 1], 8'd224);
    end
  endtask

  initial begin
    int d0;
    bit seen;
    vecs[0] = '{4'd2,  4'd3,  1'b0, 1'b0, 1'b0, 26,  6};
    vecs[1] = '{4'd2,  4'd3,  1'b0, 1'b1, 1'b0, 26,  6};
    vecs[2] = '{4'd0,  4'd7,  1'b0, 1'b0, 1'b0, 2,   0};
    vecs[3] = '{4'd15, 4'd15, 1'b1, 1'b0, 1'b0, 902, 225};
    vecs[4] = '{4'd7,  4'd0,  1'b0, 1'b1, 1'b0, 2,   0};
    vecs[5] = '{4'd1,  4'd1,  1'b1, 1'b1, 1'b0, 6,   1};
    vecs[6] = '{4'd2,  4'd3,  1'b0, 1'b0, 1'b1, 26,  6};

    RST_N = 1'b0; start = 1'b0; rows = '0; cols = '0; ready = 1'b1; rmode = 1'b0;
    fill_mem(1'b1);
    repeat (3) @(negedge CLK);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_data", data, 0);
    chk("rst_ctrl", ctrl_logic, 0);
    chk("rst_rd_addr", rd_addr, 0);
    RST_N = 1'b1;

    // Abort during SEND: async reset must clear the bus at once and swallow the done pulse.
    @(negedge CLK);
    start = 1'b1; rows = 4'd15; cols = 4'd15;
    @(negedge CLK);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge CLK);
      seen = valid && !ctrl_logic;
    end
    chk("reach_send", seen, 1);
    d0 = done_cnt;
    @(posedge CLK);
    #2 RST_N = 1'b0;
    #1;
    chk("abort_valid", valid, 0);
    chk("abort_busy", busy, 0);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    chk("abort_no_done", done_cnt - d0, 0);

    for (int k = 0; k < 7; k++) run(k);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
